id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: RV32I instruction decode stage.
// Holds the 32x32 register file, decodes the IF/ID instruction into ID/EX
// control and datapath fields, detects load-use hazards and applies
// branch flushes. Optional build macro: ID_WB_BYPASS_EN forwards a
// same-cycle writeback onto the register-file read ports.
module id_stage #(
    parameter logic [31:0] SP_INIT = 32'h0000_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_pcout,
    input  logic [31:0] IF_instrout,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_rd,
    input  logic [31:0] WB_data,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_rd,
    input  logic        BranchFlush,
    output logic        PCWrite,
    output logic        IFID_RegWrite,
    output logic [31:0] ID_pc,
    output logic [31:0] ID_rs1data,
    output logic [31:0] ID_rs2data,
    output logic [31:0] ID_imm,
    output logic [4:0]  ID_rs1,
    output logic [4:0]  ID_rs2,
    output logic [4:0]  ID_rd,
    output logic [2:0]  ID_funct3,
    output logic        ID_funct7b5,
    output logic [2:0]  ID_ALUOp,
    output logic        ID_ALUSrc,
    output logic        ID_MemRead,
    output logic        ID_MemWrite,
    output logic        ID_RegWrite,
    output logic        ID_MemtoReg,
    output logic        ID_Branch,
    output logic [1:0]  ID_Jump
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_R    = 3'b000;
    localparam logic [2:0] ALU_I    = 3'b001;
    localparam logic [2:0] ALU_ADDR = 3'b010;
    localparam logic [2:0] ALU_BR   = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;
    localparam logic [2:0] ALU_JAL  = 3'b101;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;

    // Instruction fields
    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1_idx;
    logic [REG_AW-1:0] rs2_idx;
    logic [REG_AW-1:0] rd_idx;

    assign opcode  = IF_instrout[6:0];
    assign rs1_idx = IF_instrout[19:15];
    assign rs2_idx = IF_instrout[24:20];
    assign rd_idx  = IF_instrout[11:7];

    // Register file storage
    logic [XLEN-1:0] rf_q [NREGS];

    // Decoded (pre-bubble) control and immediate
    logic [2:0]      alu_op_c;
    logic            alu_src_c;
    logic            mem_read_c;
    logic            mem_write_c;
    logic            reg_write_c;
    logic            memto_reg_c;
    logic            branch_c;
    logic [1:0]      jump_c;
    logic            rs1_used_c;
    logic            rs2_used_c;
    logic [XLEN-1:0] imm_c;

    logic [XLEN-1:0] rs1_data_c;
    logic [XLEN-1:0] rs2_data_c;
    logic            load_use_c;
    logic            bubble_c;

    // ID/EX pipeline register
    logic [XLEN-1:0]   pc_q,   pc_d;
    logic [XLEN-1:0]   rs1d_q, rs1d_d;
    logic [XLEN-1:0]   rs2d_q, rs2d_d;
    logic [XLEN-1:0]   imm_q,  imm_d;
    logic [REG_AW-1:0] rs1_q,  rs1_d;
    logic [REG_AW-1:0] rs2_q,  rs2_d;
    logic [REG_AW-1:0] rd_q,   rd_d;
    logic [2:0]        f3_q,   f3_d;
    logic              f7b5_q, f7b5_d;
    logic [2:0]        aluop_q, aluop_d;
    logic              alusrc_q, alusrc_d;
    logic              mrd_q,  mrd_d;
    logic              mwr_q,  mwr_d;
    logic              rwr_q,  rwr_d;
    logic              m2r_q,  m2r_d;
    logic              br_q,   br_d;
    logic [1:0]        jmp_q,  jmp_d;

    // Register file: x2 resets to the stack pointer, x0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= (i == 2) ? SP_INIT : '0;
            end
        end else if (WB_RegWrite && (WB_rd != '0)) begin
            rf_q[WB_rd] <= WB_data;
        end
    end

    // Combinational read ports, optionally forwarding the writeback value
    always_comb begin
        rs1_data_c = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
        rs2_data_c = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];
`ifdef ID_WB_BYPASS_EN
        if (WB_RegWrite && (WB_rd != '0) && (WB_rd == rs1_idx)) begin
            rs1_data_c = WB_data;
        end
        if (WB_RegWrite && (WB_rd != '0) && (WB_rd == rs2_idx)) begin
            rs2_data_c = WB_data;
        end
`endif
    end

    // Opcode decode: control bits, operand usage and immediate format
    always_comb begin
        alu_op_c    = ALU_R;
        alu_src_c   = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        memto_reg_c = 1'b0;
        branch_c    = 1'b0;
        jump_c      = JMP_NONE;
        rs1_used_c  = 1'b0;
        rs2_used_c  = 1'b0;
        imm_c       = '0;
        case (opcode)
            OP_R: begin
                alu_op_c    = ALU_R;
                reg_write_c = 1'b1;
                rs1_used_c  = 1'b1;
                rs2_used_c  = 1'b1;
            end
            OP_I: begin
                alu_op_c    = ALU_I;
                alu_src_c   = 1'b1;
                reg_write_c = 1'b1;
                rs1_used_c  = 1'b1;
                imm_c       = {{20{IF_instrout[31]}}, IF_instrout[31:20]};
            end
            OP_LOAD: begin
                alu_op_c    = ALU_ADDR;
                alu_src_c   = 1'b1;
                mem_read_c  = 1'b1;
                reg_write_c = 1'b1;
                memto_reg_c = 1'b1;
                rs1_used_c  = 1'b1;
                imm_c       = {{20{IF_instrout[31]}}, IF_instrout[31:20]};
            end
            OP_STORE: begin
                alu_op_c    = ALU_ADDR;
                alu_src_c   = 1'b1;
                mem_write_c = 1'b1;
                rs1_used_c  = 1'b1;
                rs2_used_c  = 1'b1;
                imm_c       = {{20{IF_instrout[31]}}, IF_instrout[31:25],
                               IF_instrout[11:7]};
            end
            OP_BRANCH: begin
                alu_op_c    = ALU_BR;
                branch_c    = 1'b1;
                rs1_used_c  = 1'b1;
                rs2_used_c  = 1'b1;
                imm_c       = {{19{IF_instrout[31]}}, IF_instrout[31], IF_instrout[7],
                               IF_instrout[30:25], IF_instrout[11:8], 1'b0};
            end
            OP_JAL: begin
                alu_op_c    = ALU_JAL;
                reg_write_c = 1'b1;
                jump_c      = JMP_JAL;
                imm_c       = {{11{IF_instrout[31]}}, IF_instrout[31], IF_instrout[19:12],
                               IF_instrout[20], IF_instrout[30:21], 1'b0};
            end
            OP_JALR: begin
                alu_op_c    = ALU_ADDR;
                alu_src_c   = 1'b1;
                reg_write_c = 1'b1;
                jump_c      = JMP_JALR;
                rs1_used_c  = 1'b1;
                imm_c       = {{20{IF_instrout[31]}}, IF_instrout[31:20]};
            end
            OP_LUI: begin
                alu_op_c    = ALU_LUI;
                alu_src_c   = 1'b1;
                reg_write_c = 1'b1;
                imm_c       = {IF_instrout[31:12], 12'b0};
            end
            OP_AUIPC: begin
                alu_op_c    = ALU_ADDR;
                alu_src_c   = 1'b1;
                reg_write_c = 1'b1;
                imm_c       = {IF_instrout[31:12], 12'b0};
            end
            default: begin
                imm_c = '0;
            end
        endcase
    end

    // Load-use hazard detection; a flush overrides the stall
    always_comb begin
        load_use_c = EX_MemRead && (EX_rd != '0) &&
                     ((rs1_used_c && (EX_rd == rs1_idx)) ||
                      (rs2_used_c && (EX_rd == rs2_idx)));
        bubble_c      = load_use_c || BranchFlush;
        PCWrite       = !(load_use_c && !BranchFlush);
        IFID_RegWrite = !(load_use_c && !BranchFlush);
    end

    // Next ID/EX contents: datapath always loads, control zeroed on a bubble
    always_comb begin
        pc_d     = IF_pcout;
        rs1d_d   = rs1_data_c;
        rs2d_d   = rs2_data_c;
        imm_d    = imm_c;
        rs1_d    = rs1_idx;
        rs2_d    = rs2_idx;
        rd_d     = rd_idx;
        f3_d     = IF_instrout[14:12];
        f7b5_d   = IF_instrout[30];
        aluop_d  = alu_op_c;
        alusrc_d = alu_src_c;
        mrd_d    = mem_read_c;
        mwr_d    = mem_write_c;
        rwr_d    = reg_write_c;
        m2r_d    = memto_reg_c;
        br_d     = branch_c;
        jmp_d    = jump_c;
        if (bubble_c) begin
            aluop_d  = '0;
            alusrc_d = 1'b0;
            mrd_d    = 1'b0;
            mwr_d    = 1'b0;
            rwr_d    = 1'b0;
            m2r_d    = 1'b0;
            br_d     = 1'b0;
            jmp_d    = '0;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            rs1d_q   <= '0;
            rs2d_q   <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            f3_q     <= '0;
            f7b5_q   <= 1'b0;
            aluop_q  <= '0;
            alusrc_q <= 1'b0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            rwr_q    <= 1'b0;
            m2r_q    <= 1'b0;
            br_q     <= 1'b0;
            jmp_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            rs1d_q   <= rs1d_d;
            rs2d_q   <= rs2d_d;
            imm_q    <= imm_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            f3_q     <= f3_d;
            f7b5_q   <= f7b5_d;
            aluop_q  <= aluop_d;
            alusrc_q <= alusrc_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
            rwr_q    <= rwr_d;
            m2r_q    <= m2r_d;
            br_q     <= br_d;
            jmp_q    <= jmp_d;
        end
    end

    assign ID_pc       = pc_q;
    assign ID_rs1data  = rs1d_q;
    assign ID_rs2data  = rs2d_q;
    assign ID_imm      = imm_q;
    assign ID_rs1      = rs1_q;
    assign ID_rs2      = rs2_q;
    assign ID_rd       = rd_q;
    assign ID_funct3   = f3_q;
    assign ID_funct7b5 = f7b5_q;
    assign ID_ALUOp    = aluop_q;
    assign ID_ALUSrc   = alusrc_q;
    assign ID_MemRead  = mrd_q;
    assign ID_MemWrite = mwr_q;
    assign ID_RegWrite = rwr_q;
    assign ID_MemtoReg = m2r_q;
    assign ID_Branch   = br_q;
    assign ID_Jump     = jmp_q;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and randomized checks of id_stage against a
// behavioural model (register array plus opcode table).
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] IF_pcout = '0;
    logic [31:0] IF_instrout = '0;
    logic        WB_RegWrite = 1'b0;
    logic [4:0]  WB_rd = '0;
    logic [31:0] WB_data = '0;
    logic        EX_MemRead = 1'b0;
    logic [4:0]  EX_rd = '0;
    logic        BranchFlush = 1'b0;
    logic        PCWrite, IFID_RegWrite;
    logic [31:0] ID_pc, ID_rs1data, ID_rs2data, ID_imm;
    logic [4:0]  ID_rs1, ID_rs2, ID_rd;
    logic [2:0]  ID_funct3, ID_ALUOp;
    logic        ID_funct7b5, ID_ALUSrc, ID_MemRead, ID_MemWrite;
    logic        ID_RegWrite, ID_MemtoReg, ID_Branch;
    logic [1:0]  ID_Jump;

    id_stage dut (
        .clk(clk), .rst(rst),
        .IF_pcout(IF_pcout), .IF_instrout(IF_instrout),
        .WB_RegWrite(WB_RegWrite), .WB_rd(WB_rd), .WB_data(WB_data),
        .EX_MemRead(EX_MemRead), .EX_rd(EX_rd), .BranchFlush(BranchFlush),
        .PCWrite(PCWrite), .IFID_RegWrite(IFID_RegWrite),
        .ID_pc(ID_pc), .ID_rs1data(ID_rs1data), .ID_rs2data(ID_rs2data), .ID_imm(ID_imm),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_funct3(ID_funct3), .ID_funct7b5(ID_funct7b5),
        .ID_ALUOp(ID_ALUOp), .ID_ALUSrc(ID_ALUSrc), .ID_MemRead(ID_MemRead),
        .ID_MemWrite(ID_MemWrite), .ID_RegWrite(ID_RegWrite), .ID_MemtoReg(ID_MemtoReg),
        .ID_Branch(ID_Branch), .ID_Jump(ID_Jump)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        known;
        logic [2:0]  aluop;
        logic        alusrc, mr, mw, rw, m2r, br;
        logic [1:0]  jmp;
        logic        r1u, r2u;
        logic [31:0] imm;
    } dec_t;

    int checks = 0;
    int errors = 0;
    logic [31:0] mrf [32];
    logic        exp_stall;
    logic        seen_pcw;
    logic [31:0] rins, rpc;
    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                              7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        logic signed [11:0] i12;
        logic signed [11:0] s12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        i12 = ins[31:20];
        s12 = {ins[31:25], ins[11:7]};
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        d = '{known: 1'b1, aluop: 3'd0, alusrc: 1'b0, mr: 1'b0, mw: 1'b0, rw: 1'b0,
              m2r: 1'b0, br: 1'b0, jmp: 2'd0, r1u: 1'b0, r2u: 1'b0, imm: 32'd0};
        case (ins[6:0])
            7'h33: begin d.rw = 1; d.r1u = 1; d.r2u = 1; end
            7'h13: begin d.aluop = 3'd1; d.alusrc = 1; d.rw = 1; d.r1u = 1; d.imm = 32'(i12); end
            7'h03: begin d.aluop = 3'd2; d.alusrc = 1; d.mr = 1; d.rw = 1; d.m2r = 1;
                         d.r1u = 1; d.imm = 32'(i12); end
            7'h23: begin d.aluop = 3'd2; d.alusrc = 1; d.mw = 1; d.r1u = 1; d.r2u = 1;
                         d.imm = 32'(s12); end
            7'h63: begin d.aluop = 3'd3; d.br = 1; d.r1u = 1; d.r2u = 1; d.imm = 32'(b13); end
            7'h6F: begin d.aluop = 3'd5; d.rw = 1; d.jmp = 2'd1; d.imm = 32'(j21); end
            7'h67: begin d.aluop = 3'd2; d.alusrc = 1; d.rw = 1; d.jmp = 2'd2; d.r1u = 1;
                         d.imm = 32'(i12); end
            7'h37: begin d.aluop = 3'd4; d.alusrc = 1; d.rw = 1; d.imm = ins & 32'hFFFF_F000; end
            7'h17: begin d.aluop = 3'd2; d.alusrc = 1; d.rw = 1; d.imm = ins & 32'hFFFF_F000; end
            default: d.known = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] r, input logic we,
                                          input logic [4:0] wr, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (we && wr == r) return wd;
`endif
        return mrf[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mrf[i] = (i == 2) ? 32'h0000_FFFC : 32'd0;
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                        input logic wbwe, input logic [4:0] wbrd, input logic [31:0] wbd,
                        input logic exmr, input logic [4:0] exrd, input logic fl);
        dec_t d;
        logic hz, bub;
        logic [31:0] v1, v2;
        @(negedge clk);
        IF_instrout = ins; IF_pcout = pc;
        WB_RegWrite = wbwe; WB_rd = wbrd; WB_data = wbd;
        EX_MemRead = exmr; EX_rd = exrd; BranchFlush = fl;
        #1;
        d  = decode(ins);
        hz = exmr && exrd != 0 && ((d.r1u && exrd == ins[19:15]) || (d.r2u && exrd == ins[24:20]));
        exp_stall = hz && !fl;
        bub = hz || fl || !d.known;
        seen_pcw = PCWrite;
        check("PCWrite", 32'(PCWrite), 32'(!exp_stall));
        check("IFID_RegWrite", 32'(IFID_RegWrite), 32'(!exp_stall));
        v1 = mread(ins[19:15], wbwe, wbrd, wbd);
        v2 = mread(ins[24:20], wbwe, wbrd, wbd);
        @(posedge clk);
        if (wbwe && wbrd != 0) mrf[wbrd] = wbd;
        #1;
        check("ID_ALUOp",    32'(ID_ALUOp),    bub ? 32'd0 : 32'(d.aluop));
        check("ID_ALUSrc",   32'(ID_ALUSrc),   bub ? 32'd0 : 32'(d.alusrc));
        check("ID_MemRead",  32'(ID_MemRead),  bub ? 32'd0 : 32'(d.mr));
        check("ID_MemWrite", 32'(ID_MemWrite), bub ? 32'd0 : 32'(d.mw));
        check("ID_RegWrite", 32'(ID_RegWrite), bub ? 32'd0 : 32'(d.rw));
        check("ID_MemtoReg", 32'(ID_MemtoReg), bub ? 32'd0 : 32'(d.m2r));
        check("ID_Branch",   32'(ID_Branch),   bub ? 32'd0 : 32'(d.br));
        check("ID_Jump",     32'(ID_Jump),     bub ? 32'd0 : 32'(d.jmp));
        if (!bub) begin
            check("ID_pc", ID_pc, pc);
            check("ID_rs1data", ID_rs1data, v1);
            check("ID_rs2data", ID_rs2data, v2);
            check("ID_imm", ID_imm, d.imm);
            check("ID_rs1", 32'(ID_rs1), 32'(ins[19:15]));
            check("ID_rs2", 32'(ID_rs2), 32'(ins[24:20]));
            check("ID_rd", 32'(ID_rd), 32'(ins[11:7]));
            check("ID_funct3", 32'(ID_funct3), 32'(ins[14:12]));
            check("ID_funct7b5", 32'(ID_funct7b5), 32'(ins[30]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ID_pc"}, ID_pc, 32'd0);
        check({tag, " ID_rs1data"}, ID_rs1data, 32'd0);
        check({tag, " ID_imm"}, ID_imm, 32'd0);
        check({tag, " ID_rd"}, 32'(ID_rd), 32'd0);
        check({tag, " ctrl"}, 32'({ID_ALUOp, ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_RegWrite,
                                   ID_MemtoReg, ID_Branch, ID_Jump}), 32'd0);
    endtask

    initial begin
        model_reset();
        // Reset state
        #2;
        check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        step(32'h0001_0013, 32'h100, 0, 0, 0, 0, 0, 0);   // addi x0,x2,0
        check("read x2", ID_rs1data, 32'h0000_FFFC);
        step(32'h0050_0033, 32'h104, 0, 0, 0, 0, 0, 0);   // add x0,x0,x5
        check("read x5", ID_rs2data, 32'd0);

        // Writes to x0 are ignored; ordinary writes become visible
        step(32'h0, 32'h108, 1, 5'd0, 32'hDEAD, 0, 0, 0);
        step(32'h0000_0093, 32'h10C, 0, 0, 0, 0, 0, 0);   // addi x1,x0,0
        check("x0 stays 0", ID_rs1data, 32'd0);
        step(32'h0, 32'h110, 1, 5'd7, 32'h1234, 0, 0, 0);
        step(32'h0070_00B3, 32'h114, 0, 0, 0, 0, 0, 0);   // add x1,x0,x7
        check("read x7", ID_rs2data, 32'h1234);

        // Same-cycle writeback and read of x9
        step(32'h0004_8013, 32'h118, 1, 5'd9, 32'h55, 0, 0, 0);
`ifdef ID_WB_BYPASS_EN
        check("x9 same cycle", ID_rs1data, 32'h55);
`else
        check("x9 same cycle", ID_rs1data, 32'h0);
`endif
        step(32'h0004_8013, 32'h11C, 0, 0, 0, 0, 0, 0);
        check("x9 later", ID_rs1data, 32'h55);

        // Load-use stall on add x6,x5,x1, then re-decode
        step(32'h0012_8333, 32'h120, 0, 0, 0, 1, 5'd5, 0);
        check("stall PCWrite", 32'(seen_pcw), 32'd0);
        check("stall bubble RegWrite", 32'(ID_RegWrite), 32'd0);
        step(32'h0012_8333, 32'h120, 0, 0, 0, 0, 0, 0);
        check("redecode RegWrite", 32'(ID_RegWrite), 32'd1);
        check("redecode rd", 32'(ID_rd), 32'd6);

        // Flush overrides the stall
        step(32'h0012_8333, 32'h124, 0, 0, 0, 1, 5'd5, 1);
        check("flush PCWrite", 32'(seen_pcw), 32'd1);
        check("flush RegWrite", 32'(ID_RegWrite), 32'd0);

        // Branch and jump immediates
        step(32'hFE00_0EE3, 32'h128, 0, 0, 0, 0, 0, 0);
        check("beq imm", ID_imm, 32'hFFFF_FFFC);
        check("beq Branch", 32'(ID_Branch), 32'd1);
        check("beq ALUOp", 32'(ID_ALUOp), 32'd3);
        step(32'h0010_00EF, 32'h12C, 0, 0, 0, 0, 0, 0);
        check("jal imm", ID_imm, 32'h0000_0800);
        check("jal Jump", 32'(ID_Jump), 32'd1);

        // Reset in the middle of a stall clears everything at once
        @(negedge clk);
        IF_instrout = 32'h0012_8333; EX_MemRead = 1'b1; EX_rd = 5'd5;
        WB_RegWrite = 1'b0; BranchFlush = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_all_zero("midstall reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(32'h0070_8013, 32'h200, 0, 0, 0, 0, 0, 0);   // addi x0,x1,7
        check("post-reset RegWrite", 32'(ID_RegWrite), 32'd1);
        step(32'h0070_00B3, 32'h204, 0, 0, 0, 0, 0, 0);   // x7 cleared by reset
        check("x7 after reset", ID_rs2data, 32'd0);

        // Randomized traffic; hold the instruction while a stall is expected
        exp_stall = 1'b0;
        rins = '0;
        rpc  = '0;
        for (int k = 0; k < 400; k++) begin
            if (!exp_stall) begin
                rins = $urandom;
                rins[6:0]   = ops[$urandom_range(0, 9)];
                rins[19:15] = 5'($urandom_range(0, 7));
                rins[24:20] = 5'($urandom_range(0, 7));
                rins[11:7]  = 5'($urandom_range(0, 7));
                rpc = $urandom & 32'hFFFF_FFFC;
            end
            step(rins, rpc, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
